delay_tracker: RTL and testbench

Adaptive delay stage for the second channel of the CDA block. It delays the raw x2 bit stream through a tapped shift line and drives the `ccd` detector's `x2_k_delayed` / `x2_k_delayed_minus_1` inputs. It also clears the `ccd` counter, samples its sign output after a fixed dwell window, and steps the delay toward alignment. The tracker reports the current delay and a lock flag to the system controller.

---
 rtl/delay_tracker.sv | 114 +++++++++++
 tb/tb_delay_tracker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_tracker.sv
// Adaptive delay stage for the CDA second channel: tapped x2 delay line plus
// a clear/dwell/decide loop that steps the tap toward alignment and flags lock.
module delay_tracker #(
  parameter int unsigned MAX_DELAY  = 64,
  parameter int unsigned DELAY_W    = 6,
  parameter int unsigned INIT_DELAY = 32,
  parameter int unsigned DWELL_LOG2 = 10,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x2_k,
  input  logic               ccd_out,
  output logic               x2_k_delayed,
  output logic               x2_k_delayed_minus_1,
  output logic               ccd_clr,
  output logic [DELAY_W-1:0] delay,
  output logic               update,
  output logic               locked
);

  localparam int unsigned REV_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TAP_W = DELAY_W + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, DWELL, DECIDE} state_t;

  state_t                state;
  logic [MAX_DELAY:0]    sr;
  logic [DWELL_LOG2-1:0] dwell_cnt;
  logic [REV_W-1:0]      rev_cnt;
  logic [REV_W-1:0]      rev_nxt;
  logic                  prev_valid;
  logic                  prev_up;
  logic                  step_up;
  logic                  step_dn;
  logic [TAP_W-1:0]      tap_idx;

  // Tap muxes; sr[0] already carries one cycle of delay.
  assign tap_idx              = {1'b0, delay};
  assign x2_k_delayed         = sr[tap_idx];
  assign x2_k_delayed_minus_1 = sr[tap_idx + TAP_W'(1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[MAX_DELAY-1:0], x2_k};
  end

  // Step direction and reversal count for the pending decision.
  always_comb begin
    step_up = ~ccd_out && (delay != DELAY_W'(MAX_DELAY - 1));
    step_dn = ccd_out && (delay != '0);
    rev_nxt = '0;
    if ((step_up || step_dn) && prev_valid && (step_up != prev_up)) begin
      if (rev_cnt != REV_W'(LOCK_COUNT)) rev_nxt = rev_cnt + REV_W'(1);
      else                               rev_nxt = rev_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dwell_cnt  <= '0;
      delay      <= DELAY_W'(INIT_DELAY);
      rev_cnt    <= '0;
      prev_valid <= 1'b0;
      prev_up    <= 1'b0;
      update     <= 1'b0;
      ccd_clr    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      update  <= 1'b0;
      ccd_clr <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        prev_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CLEAR;
            ccd_clr <= 1'b1;
          end
          CLEAR: begin
            state     <= DWELL;
            dwell_cnt <= '0;
          end
          DWELL: begin
            dwell_cnt <= dwell_cnt + DWELL_LOG2'(1);
            if (dwell_cnt == '1) state <= DECIDE;
          end
          DECIDE: begin
            // New tap lands with the CLEAR pulse so its transient is discarded.
            state   <= CLEAR;
            ccd_clr <= 1'b1;
            update  <= 1'b1;
            rev_cnt <= rev_nxt;
            locked  <= (rev_nxt == REV_W'(LOCK_COUNT));
            if (step_up) begin
              delay      <= delay + DELAY_W'(1);
              prev_valid <= 1'b1;
              prev_up    <= 1'b1;
            end else if (step_dn) begin
              delay      <= delay - DELAY_W'(1);
              prev_valid <= 1'b1;
              prev_up    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_tracker.sv
// Self-checking bench for delay_tracker against a phase-counting behavioural model.
module tb_delay_tracker;

  localparam int MAX_DELAY  = 64;
  localparam int DELAY_W    = 6;
  localparam int INIT_DELAY = 32;
  localparam int DWELL_LOG2 = 4;
  localparam int LOCK_COUNT = 4;
  localparam int PERIOD     = (1 << DWELL_LOG2) + 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               x2_k = 1'b0;
  logic               ccd_out = 1'b0;
  logic               x2_k_delayed;
  logic               x2_k_delayed_minus_1;
  logic               ccd_clr;
  logic [DELAY_W-1:0] delay;
  logic               update;
  logic               locked;

  int checks = 0;
  int errors = 0;

  delay_tracker #(
    .MAX_DELAY (MAX_DELAY),
    .DELAY_W   (DELAY_W),
    .INIT_DELAY(INIT_DELAY),
    .DWELL_LOG2(DWELL_LOG2),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .x2_k                (x2_k),
    .ccd_out             (ccd_out),
    .x2_k_delayed        (x2_k_delayed),
    .x2_k_delayed_minus_1(x2_k_delayed_minus_1),
    .ccd_clr             (ccd_clr),
    .delay               (delay),
    .update              (update),
    .locked              (locked)
  );

  always #5 clk = ~clk;

  // Model: phase -1 is idle, 0 is the clear cycle, PERIOD-1 is the decide cycle.
  typedef struct packed {
    int phase;
    int dly;
    int rev;
    int prev;
    bit upd;
    bit clr;
    bit lck;
  } model_t;

  model_t      m;
  logic [79:0] hist;

  function automatic model_t model_next(model_t c, logic en_i, logic co_i);
    model_t n;
    int     dir;
    n     = c;
    n.upd = 1'b0;
    n.clr = 1'b0;
    if (!en_i) begin
      n.phase = -1;
      n.prev  = 0;
    end else if (c.phase < 0) begin
      n.phase = 0;
      n.clr   = 1'b1;
    end else if (c.phase == PERIOD - 1) begin
      if (co_i) dir = (c.dly > 0) ? -1 : 0;
      else      dir = (c.dly < MAX_DELAY - 1) ? 1 : 0;
      if (dir == 0) n.rev = 0;
      else begin
        if (c.prev != 0 && dir != c.prev) n.rev = (c.rev < LOCK_COUNT) ? c.rev + 1 : c.rev;
        else                              n.rev = 0;
        n.prev = dir;
        n.dly  = c.dly + dir;
      end
      n.lck   = (n.rev == LOCK_COUNT);
      n.upd   = 1'b1;
      n.clr   = 1'b1;
      n.phase = 0;
    end else begin
      n.phase = c.phase + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m    <= '{-1, INIT_DELAY, 0, 0, 1'b0, 1'b0, 1'b0};
      hist <= '0;
    end else begin
      m    <= model_next(m, en, ccd_out);
      hist <= {hist[78:0], x2_k};
    end
  end

  function automatic logic exp_tap(int idx);
    return hist[7'(idx)];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; ccd_out = 1'b0; x2_k = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset(input bit mid_dwell);
    int guard;
    if (mid_dwell) begin
      en = 1'b1; ccd_out = 1'b0; guard = 0;
      while (!(m.dly == 40 && m.phase == 8) && guard < 400) begin
        @(negedge clk); x2_k = 1'($urandom); guard++;
      end
      checks++;
      if (guard >= 400) begin errors++; $display("FAIL reset_prelude_timeout: waited %0d cycles, required < 400", guard); end
      checks++;
      if (delay !== 6'd40) begin errors++; $display("FAIL reset_prelude_delay: got %0d expected 40", delay); end
    end else begin
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (delay !== 6'd32) begin errors++; $display("FAIL reset_delay: got %0d expected 32", delay); end
    checks++;
    if ({locked, update, ccd_clr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {locked, update, ccd_clr}); end
    checks++;
    if ({x2_k_delayed, x2_k_delayed_minus_1} !== 2'b00) begin errors++; $display("FAIL reset_taps: got %b expected 00", {x2_k_delayed, x2_k_delayed_minus_1}); end
    x2_k = 1'b0; en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++;
    if ({ccd_clr, update} !== 2'b10) begin errors++; $display("FAIL reset_idle_to_clear: got clr,upd=%b expected 10", {ccd_clr, update}); end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_delay_line();
    do_reset();
    repeat (40) @(negedge clk);
    x2_k = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); x2_k = 1'b0;
      checks++;
      if (x2_k_delayed !== 1'(k == 33)) begin errors++; $display("FAIL tap_pulse k=%0d: got %b expected %b", k, x2_k_delayed, k == 33); end
      checks++;
      if (x2_k_delayed_minus_1 !== 1'(k == 34)) begin errors++; $display("FAIL tap_m1_pulse k=%0d: got %b expected %b", k, x2_k_delayed_minus_1, k == 34); end
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      checks++;
      if ({x2_k_delayed, x2_k_delayed_minus_1} !== {exp_tap(m.dly), exp_tap(m.dly + 1)})
        begin errors++; $display("FAIL tap_random i=%0d: got %b expected %b", i, {x2_k_delayed, x2_k_delayed_minus_1}, {exp_tap(m.dly), exp_tap(m.dly + 1)}); end
      x2_k = 1'($urandom);
    end
  endtask

  task automatic test_step_up();
    int cyc, last_clr, n_upd;
    int exp_d[3] = '{33, 34, 35};
    do_reset();
    en = 1'b1; ccd_out = 1'b0;
    cyc = 0; last_clr = -1000; n_upd = 0;
    while (n_upd < 3 && cyc < 4 * PERIOD) begin
      @(negedge clk); cyc++;
      if (update === 1'b1) begin
        checks++;
        if (cyc - last_clr != PERIOD) begin errors++; $display("FAIL step_up_period: got %0d expected %0d", cyc - last_clr, PERIOD); end
        checks++;
        if (delay !== DELAY_W'(exp_d[n_upd])) begin errors++; $display("FAIL step_up_delay #%0d: got %0d expected %0d", n_upd, delay, exp_d[n_upd]); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL step_up_locked: got %b expected 0", locked); end
        n_upd++;
      end
      if (ccd_clr === 1'b1) last_clr = cyc;
      checks++;
      if ({update, ccd_clr} !== {m.upd, m.clr}) begin errors++; $display("FAIL step_up_pulses cyc=%0d: got %b expected %b", cyc, {update, ccd_clr}, {m.upd, m.clr}); end
    end
    checks++;
    if (n_upd != 3) begin errors++; $display("FAIL step_up_timeout: got %0d updates expected 3", n_upd); end
  endtask

  task automatic test_saturation();
    int guard;
    int dn_exp[4] = '{1, 0, 0, 0};
    int up_exp[2] = '{63, 63};
    do_reset();
    en = 1'b1; ccd_out = 1'b1; guard = 0;
    while (!(update === 1'b1 && delay === 6'd2) && guard < 40 * PERIOD) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 40 * PERIOD) begin errors++; $display("FAIL sat_down_reach: waited %0d cycles for delay 2", guard); end
    for (int i = 0; i < 4; i++) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (update !== 1'b1 && guard < 2 * PERIOD);
      checks++;
      if (update !== 1'b1 || delay !== DELAY_W'(dn_exp[i]))
        begin errors++; $display("FAIL sat_down #%0d: got upd=%b delay=%0d expected upd=1 delay=%0d", i, update, delay, dn_exp[i]); end
    end
    ccd_out = 1'b0; guard = 0;
    while (!(update === 1'b1 && delay === 6'd62) && guard < 70 * PERIOD) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 70 * PERIOD) begin errors++; $display("FAIL sat_up_reach: waited %0d cycles for delay 62", guard); end
    for (int i = 0; i < 2; i++) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (update !== 1'b1 && guard < 2 * PERIOD);
      checks++;
      if (update !== 1'b1 || delay !== DELAY_W'(up_exp[i]))
        begin errors++; $display("FAIL sat_up #%0d: got upd=%b delay=%0d expected upd=1 delay=%0d", i, update, delay, up_exp[i]); end
    end
  endtask

  task automatic test_lock();
    int cyc, n_upd;
    bit pat[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int exp_d[6] = '{33, 32, 33, 32, 33, 34};
    bit exp_l[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    en = 1'b1; ccd_out = pat[0]; cyc = 0; n_upd = 0;
    while (n_upd < 6 && cyc < 8 * PERIOD) begin
      @(negedge clk); cyc++;
      checks++;
      if (locked !== m.lck) begin errors++; $display("FAIL lock_track cyc=%0d: got %b expected %b", cyc, locked, m.lck); end
      if (update === 1'b1) begin
        checks++;
        if (delay !== DELAY_W'(exp_d[n_upd]) || locked !== exp_l[n_upd])
          begin errors++; $display("FAIL lock_decision #%0d: got delay=%0d locked=%b expected delay=%0d locked=%b", n_upd, delay, locked, exp_d[n_upd], exp_l[n_upd]); end
        n_upd++;
        if (n_upd < 6) ccd_out = pat[n_upd];
      end
    end
    checks++;
    if (n_upd != 6) begin errors++; $display("FAIL lock_timeout: got %0d decisions expected 6", n_upd); end
  endtask

  task automatic test_enable_drop();
    int cyc, n_upd, guard;
    do_reset();
    en = 1'b1; ccd_out = 1'b0; cyc = 0; n_upd = 0;
    while (n_upd < 5 && cyc < 7 * PERIOD) begin
      @(negedge clk); cyc++;
      if (update === 1'b1) begin n_upd++; ccd_out = 1'(n_upd % 2); end
    end
    checks++;
    if (n_upd != 5 || delay !== 6'd33 || locked !== 1'b1)
      begin errors++; $display("FAIL en_prelude: got n=%0d delay=%0d locked=%b expected n=5 delay=33 locked=1", n_upd, delay, locked); end
    guard = 0;
    while (m.phase != 8 && guard < 2 * PERIOD) begin @(negedge clk); guard++; end
    en = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if ({update, ccd_clr} !== 2'b00) begin errors++; $display("FAIL en_off_pulses i=%0d: got %b expected 00", i, {update, ccd_clr}); end
      checks++;
      if (delay !== 6'd33 || locked !== 1'b1) begin errors++; $display("FAIL en_off_hold i=%0d: got delay=%0d locked=%b expected 33/1", i, delay, locked); end
    end
    en = 1'b1; ccd_out = 1'b1;
    @(negedge clk);
    checks++;
    if (ccd_clr !== 1'b1) begin errors++; $display("FAIL en_restart_clear: got %b expected 1", ccd_clr); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (update !== 1'b1 && cyc < 2 * PERIOD);
    checks++;
    if (cyc != PERIOD) begin errors++; $display("FAIL en_restart_period: got %0d expected %0d", cyc, PERIOD); end
    checks++;
    if (delay !== 6'd32 || locked !== 1'b0) begin errors++; $display("FAIL en_restart_decision: got delay=%0d locked=%b expected 32/0", delay, locked); end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      checks++;
      if ({x2_k_delayed, x2_k_delayed_minus_1} !== {exp_tap(m.dly), exp_tap(m.dly + 1)})
        begin errors++; $display("FAIL rand_taps i=%0d: got %b expected %b", i, {x2_k_delayed, x2_k_delayed_minus_1}, {exp_tap(m.dly), exp_tap(m.dly + 1)}); end
      checks++;
      if (delay !== DELAY_W'(m.dly)) begin errors++; $display("FAIL rand_delay i=%0d: got %0d expected %0d", i, delay, m.dly); end
      checks++;
      if ({update, ccd_clr, locked} !== {m.upd, m.clr, m.lck})
        begin errors++; $display("FAIL rand_flags i=%0d: got %b expected %b", i, {update, ccd_clr, locked}, {m.upd, m.clr, m.lck}); end
      x2_k    = 1'($urandom);
      ccd_out = 1'($urandom);
      if ($urandom_range(99) == 0) en = ~en;
    end
  endtask

  initial begin
    test_reset(1'b0);
    test_delay_line();
    test_step_up();
    test_saturation();
    test_lock();
    test_enable_drop();
    test_reset(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
